// File: rtl/seletor_aprovados_if.sv
// seletor_aprovados_if: valid/ready channel carrying the offered node to neighbour expansion
interface seletor_aprovados_if #(
  parameter int NODE_WIDTH = 8,
  parameter int SLOT_WIDTH = 5
);
  logic                  valid_out;
  logic                  ready_in;
  logic [NODE_WIDTH-1:0] endereco_no_out;
  logic [SLOT_WIDTH-1:0] slot_out;
  modport master(output valid_out, endereco_no_out, slot_out, input ready_in);
  modport slave(input valid_out, endereco_no_out, slot_out, output ready_in);
endinterface

// File: rtl/seletor_aprovados.sv
// seletor_aprovados: snapshots approvals per round and emits them round-robin; SELETOR_APROVADOS_STATS_EN adds lifetime counters
module seletor_aprovados #(
  parameter int NUM_ATIVOS = 24,
  parameter int NODE_WIDTH = 8,
  parameter int SLOT_WIDTH = 5
) (
  input  logic                             clk_in,
  input  logic                             rst_in,
  input  logic                             tem_ativo_in,
  input  logic [NUM_ATIVOS-1:0]            aprovados_in,
  input  logic [NUM_ATIVOS*NODE_WIDTH-1:0] enderecos_in,
  input  logic                             limpar_in,
  seletor_aprovados_if.master              saida,
  output logic                             remover_out,
  output logic [NODE_WIDTH-1:0]            remover_endereco_no_out,
  output logic                             fim_rodada_out,
  output logic [SLOT_WIDTH:0]              rodada_count_out
`ifdef SELETOR_APROVADOS_STATS_EN
  ,
  output logic [15:0]                      total_emitidos_out,
  output logic [15:0]                      total_rodadas_out
`endif
);
  typedef enum logic [1:0] {IDLE, EMITE, ESPERA} state_t;
  state_t                state, state_d;
  logic [NUM_ATIVOS-1:0] mask, mask_d, mask_rest;
  logic [SLOT_WIDTH-1:0] rr_ptr, rr_d, rr_next, slot_q, slot_d, cap_sel, next_sel;
  logic [SLOT_WIDTH:0]   cnt, cnt_d, rc_d;
  logic [NODE_WIDTH-1:0] addr_q, addr_d, rem_addr_d;
  logic                  valid_q, valid_d, rem_d, fim_d, capture, accept;
  logic [NODE_WIDTH-1:0] enderecos [NUM_ATIVOS];

  for (genvar i = 0; i < NUM_ATIVOS; i++) begin : g_end
    assign enderecos[i] = enderecos_in[i*NODE_WIDTH +: NODE_WIDTH];
  end

  // first set bit of v scanning circularly upward from s
  function automatic logic [SLOT_WIDTH-1:0] pick(input logic [NUM_ATIVOS-1:0] v, input logic [SLOT_WIDTH-1:0] s);
    logic [SLOT_WIDTH-1:0] r;
    int j;
    r = '0;
    for (int k = NUM_ATIVOS - 1; k >= 0; k--) begin
      j = int'(s) + k;
      j = j >= NUM_ATIVOS ? j - NUM_ATIVOS : j;
      r = v[j[SLOT_WIDTH-1:0]] ? SLOT_WIDTH'(j) : r;
    end
    return r;
  endfunction

  assign capture   = state == IDLE && tem_ativo_in && |aprovados_in;
  assign accept    = valid_q && saida.ready_in;
  assign mask_rest = mask & ~(NUM_ATIVOS'(1) << slot_q);
  assign rr_next   = slot_q == SLOT_WIDTH'(NUM_ATIVOS - 1) ? '0 : slot_q + 1'b1;
  assign cap_sel   = pick(aprovados_in, rr_ptr);
  assign next_sel  = pick(mask_rest, rr_next);

  assign saida.valid_out       = valid_q;
  assign saida.slot_out        = slot_q;
  assign saida.endereco_no_out = addr_q;

  // next-state and next-output computation; flush overrides everything
  always_comb begin
    state_d    = state;
    mask_d     = mask;
    rr_d       = rr_ptr;
    cnt_d      = cnt;
    valid_d    = valid_q;
    slot_d     = slot_q;
    addr_d     = addr_q;
    rem_d      = 1'b0;
    rem_addr_d = remover_endereco_no_out;
    fim_d      = 1'b0;
    rc_d       = rodada_count_out;
    if (limpar_in) begin
      mask_d  = '0;
      valid_d = 1'b0;
      state_d = IDLE;
    end else begin
      case (state)
        IDLE: if (capture) begin
          mask_d  = aprovados_in;
          cnt_d   = '0;
          valid_d = 1'b1;
          slot_d  = cap_sel;
          addr_d  = enderecos[cap_sel];
          state_d = EMITE;
        end
        EMITE: if (accept) begin
          mask_d     = mask_rest;
          rr_d       = rr_next;
          cnt_d      = cnt + 1'b1;
          rem_d      = 1'b1;
          rem_addr_d = addr_q;
          slot_d     = |mask_rest ? next_sel : slot_q;
          addr_d     = |mask_rest ? enderecos[next_sel] : addr_q;
          valid_d    = |mask_rest;
          fim_d      = ~|mask_rest;
          rc_d       = |mask_rest ? rodada_count_out : cnt + 1'b1;
          state_d    = |mask_rest ? EMITE : ESPERA;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // state and registered outputs
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state                   <= IDLE;
      mask                    <= '0;
      rr_ptr                  <= '0;
      cnt                     <= '0;
      valid_q                 <= 1'b0;
      slot_q                  <= '0;
      addr_q                  <= '0;
      remover_out             <= 1'b0;
      remover_endereco_no_out <= '0;
      fim_rodada_out          <= 1'b0;
      rodada_count_out        <= '0;
    end else begin
      state                   <= state_d;
      mask                    <= mask_d;
      rr_ptr                  <= rr_d;
      cnt                     <= cnt_d;
      valid_q                 <= valid_d;
      slot_q                  <= slot_d;
      addr_q                  <= addr_d;
      remover_out             <= rem_d;
      remover_endereco_no_out <= rem_addr_d;
      fim_rodada_out          <= fim_d;
      rodada_count_out        <= rc_d;
    end
  end

`ifdef SELETOR_APROVADOS_STATS_EN
  // saturating lifetime counters of retired nodes and completed rounds
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      total_emitidos_out <= '0;
      total_rodadas_out  <= '0;
    end else begin
      if (rem_d && total_emitidos_out != 16'hFFFF) total_emitidos_out <= total_emitidos_out + 1'b1;
      if (fim_d && total_rodadas_out != 16'hFFFF) total_rodadas_out <= total_rodadas_out + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_seletor_aprovados.sv
// tb_seletor_aprovados: scoreboard bench for seletor_aprovados with a circular-scan reference model
module tb_seletor_aprovados;
  localparam int N = 24, NW = 8, SW = 5;
  logic clk = 0, rst = 1, tem = 0, limpar = 0;
  logic [N-1:0] apr = '0;
  logic [N*NW-1:0] ends = '0;
  logic rem, fim;
  logic [NW-1:0] rem_a;
  logic [SW:0] rc;
  logic [NW-1:0] a0;
`ifdef SELETOR_APROVADOS_STATS_EN
  logic [15:0] te, tr;
`endif
  seletor_aprovados_if #(.NODE_WIDTH(NW), .SLOT_WIDTH(SW)) bus();

  seletor_aprovados #(.NUM_ATIVOS(N), .NODE_WIDTH(NW), .SLOT_WIDTH(SW)) dut (
    .clk_in(clk), .rst_in(rst), .tem_ativo_in(tem), .aprovados_in(apr),
    .enderecos_in(ends), .limpar_in(limpar), .saida(bus),
    .remover_out(rem), .remover_endereco_no_out(rem_a),
    .fim_rodada_out(fim), .rodada_count_out(rc)
`ifdef SELETOR_APROVADOS_STATS_EN
    , .total_emitidos_out(te), .total_rodadas_out(tr)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {logic [SW-1:0] s; logic [NW-1:0] a;} exp_t;
  exp_t exp_q[$];
  logic [NW-1:0] rem_q[$];
  int fim_q[$];
  int checks = 0, errors = 0, fims = 0, rr = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, want);
    end
  endtask

  // monitor: retire expectations as the DUT presents emissions, removals and round ends
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (rem) begin
        if (rem_q.size() == 0) chk("remover_unexpected", rem, 0);
        else chk("remover_addr", rem_a, rem_q.pop_front());
      end
      if (bus.valid_out && bus.ready_in) begin
        if (exp_q.size() == 0) chk("emit_unexpected", bus.valid_out, 0);
        else begin
          e = exp_q.pop_front();
          chk("emit_slot", bus.slot_out, e.s);
          chk("emit_addr", bus.endereco_no_out, e.a);
          if (!limpar) begin
            rem_q.push_back(e.a);
            rr = (int'(e.s) + 1) % N;
          end
        end
      end
      if (fim) begin
        fims++;
        if (fim_q.size() == 0) chk("fim_unexpected", fim, 0);
        else chk("rodada_count", rc, fim_q.pop_front());
      end
    end
  end

  task automatic rand_ends();
    for (int i = 0; i < N*NW/32; i++) ends[i*32 +: 32] = $urandom;
  endtask

  // capture a snapshot; the model's emission order is a circular scan from the last pointer
  task automatic start_round(input logic [N-1:0] vec);
    int n;
    n = 0;
    @(posedge clk); #1;
    tem = 1;
    apr = vec;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (rr + k) % N;
      if (vec[j]) begin
        exp_q.push_back(exp_t'{s: SW'(j), a: ends[j*NW +: NW]});
        n++;
      end
    end
    fim_q.push_back(n);
    @(posedge clk); #1;
    tem = 0;
    apr = N'($urandom);
    chk("capture_latency", bus.valid_out, 1);
  endtask

  task automatic finish_round(input int p);
    int f0;
    f0 = fims;
    for (int c = 0; c < 400 && fims == f0; c++) begin
      bus.ready_in = $urandom_range(99) < p;
      @(posedge clk); #1;
    end
    chk("round_done", fims - f0, 1);
    bus.ready_in = 0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [N-1:0] vec;
    bus.ready_in = 0;
    rand_ends();
    repeat (2) @(posedge clk); #1;
    chk("rst_valid", bus.valid_out, 0);
    chk("rst_slot", bus.slot_out, 0);
    chk("rst_addr", bus.endereco_no_out, 0);
    chk("rst_remover", rem, 0);
    chk("rst_fim", fim, 0);
    chk("rst_count", rc, 0);
    rst = 0;
    // single node
    bus.ready_in = 1;
    start_round(24'h000010);
    chk("single_slot", bus.slot_out, 4);
    finish_round(100);
    chk("single_count", rc, 1);
    // backpressure: slot 0 is first from pointer 5
    start_round(24'h000005);
    a0 = bus.endereco_no_out;
    chk("bp_slot", bus.slot_out, 0);
    chk("bp_addr", a0, ends[0 +: NW]);
    repeat (5) begin
      @(posedge clk); #1;
      chk("bp_hold_valid", bus.valid_out, 1);
      chk("bp_hold_slot", bus.slot_out, 0);
      chk("bp_hold_addr", bus.endereco_no_out, a0);
      chk("bp_no_remover", rem, 0);
    end
    finish_round(100);
    chk("bp_count", rc, 2);
    // round-robin wrap from pointer 20
    start_round(24'h080000);
    finish_round(100);
    bus.ready_in = 1;
    start_round(24'h800003);
    chk("wrap_slot0", bus.slot_out, 23);
    @(posedge clk); #1;
    chk("wrap_slot1", bus.slot_out, 0);
    chk("wrap_valid1", bus.valid_out, 1);
    @(posedge clk); #1;
    chk("wrap_slot2", bus.slot_out, 1);
    chk("wrap_valid2", bus.valid_out, 1);
    finish_round(100);
    chk("wrap_count", rc, 3);
    // snapshot isolation
    start_round(24'h000003);
    tem = 1;
    apr = '1;
    repeat (3) @(posedge clk);
    #1;
    tem = 0;
    apr = '0;
    finish_round(100);
    chk("iso_count", rc, 2);
    // idle ignores approvals without tem_ativo
    apr = '1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_ignore", bus.valid_out, 0);
    apr = '0;
    // flush on the second of three nodes
    bus.ready_in = 1;
    start_round(24'h000111);
    @(posedge clk); #1;
    limpar = 1;
    @(posedge clk); #1;
    limpar = 0;
    bus.ready_in = 0;
    exp_q.delete();
    fim_q.delete();
    chk("flush_valid", bus.valid_out, 0);
    chk("flush_no_remover", rem, 0);
    chk("flush_no_fim", fim, 0);
    chk("flush_count_kept", rc, 2);
    repeat (3) begin
      @(posedge clk); #1;
      chk("flush_idle_valid", bus.valid_out, 0);
    end
    // randomized rounds
    for (int r = 0; r < 30; r++) begin
      rand_ends();
      vec = N'($urandom);
      if (vec == 0) vec = 24'h000001;
      start_round(vec);
      finish_round($urandom_range(30, 100));
    end
    // asynchronous reset mid-round with a removal pulse in flight
    start_round(24'h000007);
    bus.ready_in = 1;
    @(posedge clk); #2;
    chk("pre_rst_remover", rem, 1);
    rst = 1;
    #1;
    chk("arst_valid", bus.valid_out, 0);
    chk("arst_remover", rem, 0);
    chk("arst_fim", fim, 0);
`ifdef SELETOR_APROVADOS_STATS_EN
    chk("arst_total_emitidos", te, 0);
    chk("arst_total_rodadas", tr, 0);
`endif
    exp_q.delete();
    rem_q.delete();
    fim_q.delete();
    rr = 0;
    bus.ready_in = 0;
    @(posedge clk); #1;
    rst = 0;
    rand_ends();
    start_round(24'h00A0C1);
    finish_round(70);
    chk("queues_empty", exp_q.size() + rem_q.size() + fim_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
